// File: rtl/mux_header.sv
// Shared constants and FSM state encoding for the VSK/NSK RX demultiplexer.
// Constants only; no logic.
package mux_header;

  localparam int MSB_RAM     = 31;
  localparam int RANG_CNT_RX = MSB_RAM;
  localparam int FOUR        = 4;
  localparam int NULL        = 0;
  localparam int ONE         = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/dec_strobe_sync.sv
// Brings dec_ce_n into clk_15_o and emits a one-cycle pulse per rising edge.
// Latency 3 cycles from the input edge; no backpressure.
module dec_strobe_sync (
  input  logic clk_15_o,
  input  logic nrst,
  input  logic dec_ce_n,
  output logic strb
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
      strb   <= 1'b0;
    end else begin
      sync_1 <= dec_ce_n;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      strb   <= sync_2 & ~sync_3;
    end
  end

endmodule

// File: rtl/demux_v_n_dec.sv
// Streams 32-bit RX RAM words LSB first onto the VSK or NSK serial decoder input.
// Bit lands one cycle after its strobe; reads prefetch one word ahead, underrun is sticky.
module demux_v_n_dec
  import mux_header::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic                clk_15_o,
  input  logic                nrst,
  input  logic                mvsk_on,
  input  logic                mnsk_on,
  input  logic                dec_ce_n,
  input  logic [RAM_AW-1:0]   ram_wr_ptr,
  output logic                ram_rd_en,
  output logic [RAM_AW-1:0]   ram_rd_addr,
  input  logic [MSB_RAM:NULL] ram_rd_data,
  output logic                dec_data_v,
  output logic                dec_data_n,
  output logic                dec_bit_valid,
  output logic [FOUR:NULL]    cnt_data,
  output logic                underrun
);

  localparam int               CW       = FOUR + 1;
  localparam logic [FOUR:NULL] CNT_LAST = CW'(RANG_CNT_RX);

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           mode_q;
  logic                 abort;
  logic                 ram_empty;
  logic                 nsk_strb;
  logic                 run_strb;
  logic                 wrap;
  logic                 prefetch;
  logic                 rd_pend;
  logic                 hold_vld;
  logic [MSB_RAM:NULL]  shift_q;
  logic [MSB_RAM:NULL]  hold_q;
  logic                 cur_bit;
  logic                 dv_nxt;
  logic                 dn_nxt;
  logic                 vld_nxt;

  dec_strobe_sync u_strobe_sync (
    .clk_15_o (clk_15_o),
    .nrst     (nrst),
    .dec_ce_n (dec_ce_n),
    .strb     (nsk_strb)
  );

  // Any change of the mode pair is treated like switching off: restart from IDLE.
  assign abort     = !(mvsk_on || mnsk_on) || ({mvsk_on, mnsk_on} != mode_q);
  assign ram_empty = (ram_wr_ptr == ram_rd_addr);
  assign run_strb  = (state == RUN) && !abort && (mvsk_on || nsk_strb);
  assign wrap      = run_strb && (cnt_data == CNT_LAST);
  assign prefetch  = (state == RUN) && !hold_vld && !rd_pend && !ram_empty;
  assign cur_bit   = shift_q[cnt_data];

  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!ram_empty) state_nxt = FETCH;
        FETCH:   state_nxt = WAIT;
        WAIT:    state_nxt = RUN;
        RUN:     if (wrap && !hold_vld && !rd_pend) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ram_rd_en = !abort && ((state == FETCH) || prefetch);
    vld_nxt   = run_strb;
    dv_nxt    = dec_data_v;
    dn_nxt    = dec_data_n;
    if (abort || (state != RUN)) begin
      dv_nxt = 1'b0;
      dn_nxt = 1'b0;
    end else if (run_strb) begin
      dv_nxt = mvsk_on & cur_bit;
      dn_nxt = ~mvsk_on & cur_bit;
    end
  end

  always_ff @(posedge clk_15_o or negedge nrst) begin
    if (!nrst) begin
      mode_q        <= 2'b00;
      rd_pend       <= 1'b0;
      ram_rd_addr   <= '0;
      cnt_data      <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_vld      <= 1'b0;
      underrun      <= 1'b0;
      dec_data_v    <= 1'b0;
      dec_data_n    <= 1'b0;
      dec_bit_valid <= 1'b0;
    end else begin
      mode_q        <= {mvsk_on, mnsk_on};
      rd_pend       <= ram_rd_en;
      dec_data_v    <= dv_nxt;
      dec_data_n    <= dn_nxt;
      dec_bit_valid <= vld_nxt;
      if (abort) begin
        cnt_data <= '0;
        hold_vld <= 1'b0;
        underrun <= 1'b0;
      end else begin
        case (state)
          WAIT: begin
            shift_q     <= ram_rd_data;
            cnt_data    <= '0;
            ram_rd_addr <= ram_rd_addr + RAM_AW'(1);
          end
          RUN: begin
            // A prefetch return lands in hold, or straight in shift when it meets the wrap.
            if (rd_pend) begin
              ram_rd_addr <= ram_rd_addr + RAM_AW'(1);
              if (!wrap) begin
                hold_q   <= ram_rd_data;
                hold_vld <= 1'b1;
              end
            end
            if (run_strb) begin
              if (wrap) begin
                cnt_data <= '0;
                if (hold_vld) begin
                  shift_q  <= hold_q;
                  hold_vld <= 1'b0;
                end else if (rd_pend) begin
                  shift_q <= ram_rd_data;
                end else begin
                  underrun <= 1'b1;
                end
              end else begin
                cnt_data <= cnt_data + CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_v_n_dec.sv
// Directed bench for demux_v_n_dec with a bit/address scoreboard and a 4-word RAM model.
module tb_demux_v_n_dec;
  import mux_header::*;

  localparam int AW = 2;

  logic          clk_15_o;
  logic          nrst;
  logic          mvsk_on;
  logic          mnsk_on;
  logic          dec_ce_n;
  logic [AW-1:0] ram_wr_ptr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [31:0]   ram_rd_data;
  logic          dec_data_v;
  logic          dec_data_n;
  logic          dec_bit_valid;
  logic [4:0]    cnt_data;
  logic          underrun;

  logic [31:0]   mem [4];
  logic [1:0]    exp_bits [$];
  logic [AW-1:0] exp_addr [$];
  logic          sb_en;
  int            tests;
  int            fails;
  int            bit_idx;

  demux_v_n_dec #(.RAM_AW(AW)) dut (
    .clk_15_o      (clk_15_o),
    .nrst          (nrst),
    .mvsk_on       (mvsk_on),
    .mnsk_on       (mnsk_on),
    .dec_ce_n      (dec_ce_n),
    .ram_wr_ptr    (ram_wr_ptr),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .dec_data_v    (dec_data_v),
    .dec_data_n    (dec_data_n),
    .dec_bit_valid (dec_bit_valid),
    .cnt_data      (cnt_data),
    .underrun      (underrun)
  );

  initial clk_15_o = 1'b0;
  always #5 clk_15_o = ~clk_15_o;

  initial ram_rd_data = 32'h0;
  always @(posedge clk_15_o) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic vsk);
    for (int i = 0; i < 32; i++) begin
      exp_bits.push_back(vsk ? {w[i], 1'b0} : {1'b0, w[i]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_15_o);
    #1;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_bits.size() != 0 || exp_addr.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(exp_bits.size() + exp_addr.size()), 32'd0);
  endtask

  always @(negedge clk_15_o) begin
    if (sb_en && nrst) begin
      if (dec_bit_valid) begin
        if (exp_bits.size() == 0) begin
          chk("bit_expected", 32'(exp_bits.size() > 0), 32'd1);
        end else begin
          chk($sformatf("bit_%0d", bit_idx), {30'd0, dec_data_v, dec_data_n}, {30'd0, exp_bits.pop_front()});
        end
        bit_idx++;
      end
      if (ram_rd_en) begin
        if (exp_addr.size() == 0) begin
          chk("rd_expected", 32'(exp_addr.size() > 0), 32'd1);
        end else begin
          chk("rd_addr", 32'(ram_rd_addr), 32'(exp_addr.pop_front()));
        end
      end
    end
  end

  initial begin
    int n;
    int run;
    tests = 0; fails = 0; bit_idx = 0;
    nrst = 1'b0; mvsk_on = 1'b0; mnsk_on = 1'b0; dec_ce_n = 1'b0;
    ram_wr_ptr = '0; sb_en = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;

    step(3);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk("rst_cnt", 32'(cnt_data), 32'd0);
    chk("rst_outs", {29'd0, dec_bit_valid, dec_data_v, dec_data_n}, 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    nrst = 1'b1;
    step(1);

    // VSK: two words, 64 contiguous bits, then underrun
    mem[0] = 32'h0000_0001; mem[1] = 32'h8000_0000;
    exp_addr.push_back(2'd0); exp_addr.push_back(2'd1);
    push_word(mem[0], 1'b1); push_word(mem[1], 1'b1);
    ram_wr_ptr = 2'd2; mvsk_on = 1'b1;
    n = 0;
    while (!dec_bit_valid && n < 20) begin step(1); n++; end
    run = 0;
    while (dec_bit_valid && run < 100) begin run++; step(1); end
    chk("vsk_contig", 32'(run), 32'd64);
    wait_sb("vsk_drain", 20);
    step(2);
    chk("vsk_underrun", 32'(underrun), 32'd1);
    chk("vsk_idle", 32'(dut.state), 32'(IDLE));
    chk("vsk_addr", 32'(ram_rd_addr), 32'd2);
    mvsk_on = 1'b0;
    step(2);
    chk("vsk_underrun_clr", 32'(underrun), 32'd0);

    // Single word underrun
    mem[2] = 32'h1234_5678;
    exp_addr.push_back(2'd2); push_word(mem[2], 1'b1);
    ram_wr_ptr = 2'd3; mvsk_on = 1'b1;
    wait_sb("ur_drain", 100);
    step(3);
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_idle", 32'(dut.state), 32'(IDLE));
    chk("ur_cnt", 32'(cnt_data), 32'd0);
    chk("ur_outs", {30'd0, dec_data_v, dec_data_n}, 32'd0);
    mvsk_on = 1'b0;
    step(2);
    chk("ur_clr", 32'(underrun), 32'd0);

    // Address wrap 3 -> 0 with both modes high (VSK wins)
    mem[3] = 32'hDEAD_BEEF; mem[0] = 32'h0F0F_00FF;
    exp_addr.push_back(2'd3); exp_addr.push_back(2'd0);
    push_word(mem[3], 1'b1); push_word(mem[0], 1'b1);
    ram_wr_ptr = 2'd1; mvsk_on = 1'b1; mnsk_on = 1'b1;
    wait_sb("wrap_drain", 200);
    step(2);
    chk("wrap_addr", 32'(ram_rd_addr), 32'd1);
    chk("wrap_underrun", 32'(underrun), 32'd1);
    mvsk_on = 1'b0; mnsk_on = 1'b0;
    step(2);

    // NSK with dec_ce_n period 10 cycles
    mem[1] = 32'hA5A5_A5A5;
    exp_addr.push_back(2'd1); push_word(mem[1], 1'b0);
    ram_wr_ptr = 2'd2; mnsk_on = 1'b1;
    step(8);
    for (int p = 0; p < 32; p++) begin
      #2 dec_ce_n = 1'b1;
      step(5);
      #2 dec_ce_n = 1'b0;
      step(5);
    end
    wait_sb("nsk_drain", 20);
    chk("nsk_underrun", 32'(underrun), 32'd1);
    mnsk_on = 1'b0;
    step(2);

    // Mode toggle mid-word
    sb_en = 1'b0;
    mem[2] = 32'hFFFF_FFFF;
    ram_wr_ptr = 2'd3; mvsk_on = 1'b1; mnsk_on = 1'b1;
    n = 0;
    while (cnt_data != 5'd10 && n < 50) begin step(1); n++; end
    chk("tgl_reach", 32'(cnt_data), 32'd10);
    mnsk_on = 1'b0;
    step(1);
    chk("tgl_idle", 32'(dut.state), 32'(IDLE));
    chk("tgl_cnt", 32'(cnt_data), 32'd0);
    chk("tgl_outs", {29'd0, dec_bit_valid, dec_data_v, dec_data_n}, 32'd0);
    step(1);
    chk("tgl_addr_kept", 32'(ram_rd_addr), 32'd3);
    mvsk_on = 1'b0;
    step(2);

    // Reset mid-word, restart from address 0
    ram_wr_ptr = 2'd1; mvsk_on = 1'b1;
    n = 0;
    while (cnt_data != 5'd17 && n < 60) begin step(1); n++; end
    chk("mrst_reach", 32'(cnt_data), 32'd17);
    nrst = 1'b0;
    #1;
    chk("mrst_outs", {29'd0, dec_bit_valid, dec_data_v, dec_data_n}, 32'd0);
    chk("mrst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("mrst_addr", 32'(ram_rd_addr), 32'd0);
    chk("mrst_cnt", 32'(cnt_data), 32'd0);
    mem[0] = 32'hC3C3_0F0F;
    exp_addr.push_back(2'd0); push_word(mem[0], 1'b1);
    sb_en = 1'b1;
    step(1);
    nrst = 1'b1;
    wait_sb("mrst_drain", 100);
    step(2);
    chk("mrst_underrun", 32'(underrun), 32'd1);
    chk("mrst_final_addr", 32'(ram_rd_addr), 32'd1);
    mvsk_on = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
